// File: rtl/noc_router_pkg.sv
// Shared NoC router definitions.
// Contents:
//   - Port index constants (LOCAL, NORTH, SOUTH, EAST, WEST) used to
//     address input and output ports of the router.
//   - alloc_state_e: state type of the per-output-port allocator.
//     IDLE   : the output is free; a head flit may win arbitration.
//     LOCKED : a multi-flit packet owns the output until its tail passes.
package noc_router_pkg;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int SOUTH = 2;
  localparam int EAST  = 3;
  localparam int WEST  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The first set bit of eligible is chosen, scanning upward from rr_ptr
// and wrapping modulo NUM_INPUTS. The pointer itself lives in the caller,
// so the same block can be reused wherever a rotating priority is needed.
// Ports:
//   eligible   in  NUM_INPUTS  request vector, already masked by the caller
//   rr_ptr     in  IDX_WIDTH   index with highest priority this cycle
//   winner     out NUM_INPUTS  one-hot grant, zero when nothing is eligible
//   winner_idx out IDX_WIDTH   index of the winner, zero when nothing is eligible
//   any        out 1           at least one eligible bit
module rr_arbiter #(
  parameter int NUM_INPUTS = 5,
  parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] eligible,
  input  logic [IDX_WIDTH-1:0]  rr_ptr,
  output logic [NUM_INPUTS-1:0] winner,
  output logic [IDX_WIDTH-1:0]  winner_idx,
  output logic                  any
);

  int idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_INPUTS;
      if (!any && eligible[idx]) begin
        any         = 1'b1;
        winner_idx  = IDX_WIDTH'(idx);
        winner[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output-port switch allocator and credit tracker.
// Arbitrates wormhole packets from NUM_INPUTS input buffers onto a single
// output link. A head flit wins round-robin arbitration in the cycle it is
// presented (zero-latency grant); a multi-flit packet then locks the output
// to its owner until the tail flit is transferred. Every flit is gated on a
// downstream credit.
// Ports:
//   clk           in  1           NoC clock
//   rst           in  1           synchronous active-high reset
//   req           in  NUM_INPUTS  input i has a flit routed to this port
//   req_is_tail   in  NUM_INPUTS  the head-of-buffer flit of input i is a tail
//   turn_disable  in  NUM_INPUTS  input i may never start a packet here
//   credit_in     in  1           downstream returned one credit
//   grant         out NUM_INPUTS  one-hot, combinational transfer strobe
//   send          out 1           OR of grant; output link register loads
//   owner_idx     out IDX_WIDTH   granted (IDLE) or locked owner index
//   locked        out 1           a packet is in flight (state LOCKED)
//   credit_count  out CRED_WIDTH  current downstream credit count
//   credit_err    out 1           sticky: credit returned while already full
//
// Handshake: grant[i] is the only transfer qualifier. Input i dequeues its
// head flit in exactly the cycles where grant[i]=1; req is not required to
// stay stable across cycles and no ready signal is involved.
module output_port_allocator
  import noc_router_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int IDX_WIDTH         = $clog2(NUM_INPUTS),
  parameter int CRED_WIDTH        = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [NUM_INPUTS-1:0] req_is_tail,
  input  logic [NUM_INPUTS-1:0] turn_disable,
  input  logic                  credit_in,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  send,
  output logic [IDX_WIDTH-1:0]  owner_idx,
  output logic                  locked,
  output logic [CRED_WIDTH-1:0] credit_count,
  output logic                  credit_err
);

  localparam logic [CRED_WIDTH-1:0] CRED_MAX = CRED_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [IDX_WIDTH-1:0]  IDX_LAST = IDX_WIDTH'(NUM_INPUTS - 1);

  alloc_state_e          state, state_next;
  logic [IDX_WIDTH-1:0]  owner, owner_next;
  logic [IDX_WIDTH-1:0]  rr_ptr, rr_ptr_next;
  logic [CRED_WIDTH-1:0] credit_next;
  logic                  err_set;

  logic [NUM_INPUTS-1:0] eligible;
  logic [NUM_INPUTS-1:0] arb_winner;
  logic [IDX_WIDTH-1:0]  arb_idx;
  logic                  arb_any;
  logic                  has_credit;

  assign eligible   = req & ~turn_disable;
  assign has_credit = (credit_count != '0);

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_arb (
    .eligible   (eligible),
    .rr_ptr     (rr_ptr),
    .winner     (arb_winner),
    .winner_idx (arb_idx),
    .any        (arb_any)
  );

  // Next-state, grant and owner_idx. Grants are suppressed while rst is
  // high so nothing leaves the port during reset.
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    rr_ptr_next = rr_ptr;
    grant       = '0;
    owner_idx   = owner;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (has_credit && arb_any) begin
            grant     = arb_winner;
            owner_idx = arb_idx;
            if (req_is_tail[arb_idx]) begin
              // Single-flit packet: port stays free, priority rotates.
              rr_ptr_next = (arb_idx == IDX_LAST) ? '0 : arb_idx + IDX_WIDTH'(1);
            end else begin
              state_next = LOCKED;
              owner_next = arb_idx;
            end
          end
        end
        LOCKED: begin
          // turn_disable is not consulted: the owner already passed it at
          // the head, and a bubble (req low) simply holds the lock.
          if (req[owner] && has_credit) begin
            grant[owner] = 1'b1;
            if (req_is_tail[owner]) begin
              state_next  = IDLE;
              rr_ptr_next = (owner == IDX_LAST) ? '0 : owner + IDX_WIDTH'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign send   = |grant;
  assign locked = (state == LOCKED);

  // Credit update: count - send + credit_in. A send is only possible with
  // a nonzero count, so the decrement cannot underflow. A return at full
  // with no send is a protocol error; the count saturates.
  always_comb begin
    credit_next = credit_count;
    err_set     = 1'b0;
    unique case ({send, credit_in})
      2'b10: credit_next = credit_count - CRED_WIDTH'(1);
      2'b01: begin
        if (credit_count == CRED_MAX) err_set = 1'b1;
        else                          credit_next = credit_count + CRED_WIDTH'(1);
      end
      default: credit_next = credit_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      credit_count <= CRED_MAX;
      credit_err   <= 1'b0;
    end else begin
      state        <= state_next;
      owner        <= owner_next;
      rr_ptr       <= rr_ptr_next;
      credit_count <= credit_next;
      if (err_set) credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator (NUM_INPUTS=5, DEPTH=2).
// Inputs change on the falling edge; combinational outputs are checked 1ns
// later, registered outputs 1ns after the rising edge.
module tb_output_port_allocator;
  import noc_router_pkg::*;

  localparam int N  = 5;
  localparam int IW = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_is_tail = '0;
  logic [N-1:0]  turn_disable = '0;
  logic          credit_in = 1'b0;
  logic [N-1:0]  grant;
  logic          send;
  logic [IW-1:0] owner_idx;
  logic          locked;
  logic [CW-1:0] credit_count;
  logic          credit_err;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_g;

  output_port_allocator #(
    .NUM_INPUTS        (N),
    .FLIT_BUFFER_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_is_tail  (req_is_tail),
    .turn_disable (turn_disable),
    .credit_in    (credit_in),
    .grant        (grant),
    .send         (send),
    .owner_idx    (owner_idx),
    .locked       (locked),
    .credit_count (credit_count),
    .credit_err   (credit_err)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] t,
                       input logic [N-1:0] d, input logic c);
    @(negedge clk);
    req          = r;
    req_is_tail  = t;
    turn_disable = d;
    credit_in    = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state, grant gated during rst ----------------
    rst = 1'b1;
    drive(5'b11111, 5'b11111, 5'b00000, 1'b0);
    tick();
    @(negedge clk); #1;
    chk("rst_grant",  32'(grant), 32'd0);
    chk("rst_send",   32'(send), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_cred",   32'(credit_count), 32'd2);
    chk("rst_err",    32'(credit_err), 32'd0);

    // ---------------- single-flit packet from input 2 ----------------
    @(negedge clk);
    rst = 1'b0;
    req = 5'b00100; req_is_tail = 5'b00100; turn_disable = '0; credit_in = 1'b0;
    #1;
    chk("sf_grant", 32'(grant), 32'b00100);
    chk("sf_send",  32'(send), 32'd1);
    chk("sf_owner", 32'(owner_idx), 32'(SOUTH));
    tick();
    chk("sf_cred",   32'(credit_count), 32'd1);
    chk("sf_locked", 32'(locked), 32'd0);
    // rr_ptr is now 3: with everyone requesting, input 3 wins
    drive(5'b11111, 5'b11111, 5'b00000, 1'b1);
    chk("rr3_grant", 32'(grant), 32'b01000);
    tick();
    chk("rr3_cred", 32'(credit_count), 32'd1);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
    tick();
    chk("refill_cred", 32'(credit_count), 32'd2);

    // ---------------- inputs 1 and 3, 3-flit packets (rr_ptr=4) ----------------
    drive(5'b01010, 5'b00000, 5'b00000, 1'b1);
    chk("p1_f0_grant", 32'(grant), 32'b00010);
    chk("p1_f0_owner", 32'(owner_idx), 32'd1);
    tick();
    chk("p1_f0_locked", 32'(locked), 32'd1);
    drive(5'b01010, 5'b00000, 5'b00000, 1'b1);
    chk("p1_f1_grant", 32'(grant), 32'b00010);
    chk("p1_f1_owner", 32'(owner_idx), 32'd1);
    tick();
    drive(5'b01010, 5'b00010, 5'b00000, 1'b1);
    chk("p1_f2_grant", 32'(grant), 32'b00010);
    tick();
    chk("p1_end_locked", 32'(locked), 32'd0);
    chk("p1_end_cred", 32'(credit_count), 32'd2);
    drive(5'b01000, 5'b00000, 5'b00000, 1'b1);
    chk("p3_f0_grant", 32'(grant), 32'b01000);
    chk("p3_f0_owner", 32'(owner_idx), 32'd3);
    tick();
    chk("p3_f0_locked", 32'(locked), 32'd1);
    drive(5'b01000, 5'b00000, 5'b00000, 1'b1);
    chk("p3_f1_grant", 32'(grant), 32'b01000);
    tick();
    drive(5'b01000, 5'b01000, 5'b00000, 1'b1);
    chk("p3_f2_grant", 32'(grant), 32'b01000);
    tick();
    chk("p3_end_locked", 32'(locked), 32'd0);
    chk("p3_end_cred", 32'(credit_count), 32'd2);

    // ---------------- credit starvation, input 0 4-flit packet (rr_ptr=4) ----------------
    drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
    chk("cs_f0_grant", 32'(grant), 32'b00001);
    tick();
    chk("cs_f0_cred", 32'(credit_count), 32'd1);
    drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
    chk("cs_f1_grant", 32'(grant), 32'b00001);
    tick();
    chk("cs_f1_cred", 32'(credit_count), 32'd0);
    drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
    chk("cs_stall_grant", 32'(grant), 32'd0);
    chk("cs_stall_send", 32'(send), 32'd0);
    chk("cs_stall_owner", 32'(owner_idx), 32'd0);
    chk("cs_stall_locked", 32'(locked), 32'd1);
    tick();
    drive(5'b00001, 5'b00000, 5'b00000, 1'b1);
    chk("cs_ret_grant", 32'(grant), 32'd0);
    tick();
    chk("cs_ret_cred", 32'(credit_count), 32'd1);
    drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
    chk("cs_f2_grant", 32'(grant), 32'b00001);
    tick();
    chk("cs_f2_cred", 32'(credit_count), 32'd0);
    drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
    chk("cs_stall2_grant", 32'(grant), 32'd0);
    drive(5'b00001, 5'b00000, 5'b00000, 1'b1);
    tick();
    chk("cs_ret2_cred", 32'(credit_count), 32'd1);
    // tail flit with simultaneous credit return: count unchanged
    drive(5'b00001, 5'b00001, 5'b00000, 1'b1);
    chk("cs_f3_grant", 32'(grant), 32'b00001);
    tick();
    chk("cs_net0_cred", 32'(credit_count), 32'd1);
    chk("cs_end_locked", 32'(locked), 32'd0);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
    tick();
    chk("cs_refill", 32'(credit_count), 32'd2);

    // ---------------- turn_disable masks input 1 (rr_ptr=1) ----------------
    for (int k = 0; k < 20; k++) begin
      drive(5'b00011, 5'b00011, 5'b00010, 1'b1);
      chk($sformatf("td_grant_%0d", k), 32'(grant), 32'b00001);
      tick();
    end
    chk("td_locked", 32'(locked), 32'd0);
    chk("td_cred", 32'(credit_count), 32'd2);
    // owner keeps the port when its turn is disabled mid-packet
    drive(5'b00010, 5'b00000, 5'b00000, 1'b1);
    chk("tdl_head_grant", 32'(grant), 32'b00010);
    tick();
    drive(5'b00010, 5'b00010, 5'b00010, 1'b1);
    chk("tdl_tail_grant", 32'(grant), 32'b00010);
    tick();
    chk("tdl_locked", 32'(locked), 32'd0);

    // ---------------- reset mid-packet at zero credit (rr_ptr=2) ----------------
    drive(5'b00100, 5'b00000, 5'b00000, 1'b0);
    chk("rm_f0_grant", 32'(grant), 32'b00100);
    tick();
    drive(5'b00100, 5'b00000, 5'b00000, 1'b0);
    chk("rm_f1_grant", 32'(grant), 32'b00100);
    tick();
    chk("rm_pre_cred", 32'(credit_count), 32'd0);
    chk("rm_pre_locked", 32'(locked), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    credit_in = 1'b1;
    #1;
    chk("rm_rst_grant", 32'(grant), 32'd0);
    tick();
    chk("rm_locked", 32'(locked), 32'd0);
    chk("rm_cred", 32'(credit_count), 32'd2);
    chk("rm_err", 32'(credit_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = '0; req_is_tail = '0; turn_disable = '0; credit_in = 1'b1;
    tick();
    chk("ovf_err", 32'(credit_err), 32'd1);
    chk("ovf_cred", 32'(credit_count), 32'd2);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
    tick();
    tick();
    chk("ovf_err_sticky", 32'(credit_err), 32'd1);

    // ---------------- fairness, rr_ptr=0 after reset ----------------
    for (int k = 0; k < 10; k++) exp_q.push_back(5'b00001 << (k % 5));
    for (int k = 0; k < 10; k++) begin
      drive(5'b11111, 5'b11111, 5'b00000, 1'b1);
      exp_g = exp_q.pop_front();
      chk($sformatf("fair_grant_%0d", k), 32'(grant), 32'(exp_g));
      chk($sformatf("fair_owner_%0d", k), 32'(owner_idx), 32'(k % 5));
      tick();
    end
    chk("fair_err_sticky", 32'(credit_err), 32'd1);
    chk("fair_q_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- reset clears the sticky error ----------------
    @(negedge clk);
    rst = 1'b1;
    req = '0; req_is_tail = '0; credit_in = 1'b0;
    tick();
    chk("final_err_clr", 32'(credit_err), 32'd0);
    chk("final_cred", 32'(credit_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
